// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl
//   Driving end of the shared-bus assert/load strobe protocol. A request names
//   a source slot and a destination slot. The controller holds the source's
//   active-low assert strobe for SETTLE cycles so the bus can settle, and then
//   for one more cycle together with the destination's active-low load strobe.
//   It ends with a one-cycle done pulse. The resolved bus value comes
//   combinationally from the slot outputs and enables: the lowest enabled
//   index wins, and the bus floats to FLOAT_VALUE when no slot drives it.
//
//   Optional build macro: BUS_XFER_CONTENTION_EN
//     When defined, the controller flags bus contention during DRIVE/LOAD.
//     Contention means more than one enable is set, or the source enable is
//     missing. A flagged transfer still completes, and err is raised with
//     done.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req, src, dst       transfer request; src/dst are sampled on accept
//   ready               high only in IDLE; accept = req & ready at posedge
//   done, err           one-cycle completion pulse; err is valid with done
//   reg_bus_out         concatenated slot outputs, slot k at [k*WIDTH +: WIDTH]
//   reg_bus_en          per-slot bus enables, active high
//   assert_n, load_n    per-slot active-low strobes (registered)
//   bus_value           resolved bus value (combinational)
module bus_xfer_ctrl #(
    parameter int                 WIDTH       = 8,
    parameter int                 N           = 4,
    parameter int                 IDXW        = 2,
    parameter int                 SETTLE      = 1,
    parameter logic [WIDTH-1:0]   FLOAT_VALUE = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [IDXW-1:0]       src,
    input  logic [IDXW-1:0]       dst,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    input  logic [N*WIDTH-1:0]    reg_bus_out,
    input  logic [N-1:0]          reg_bus_en,
    output logic [N-1:0]          assert_n,
    output logic [N-1:0]          load_n,
    output logic [WIDTH-1:0]      bus_value
);

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, DONE} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [IDXW-1:0] src_q;
    logic [IDXW-1:0] dst_q;
    logic            cont;
    logic            cont_now;
    logic            reject;

    function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] i);
        return N'(1) << i;
    endfunction

    // Lowest enabled index wins, so the loop runs downward and the last
    // match found is the lowest index.
    always_comb begin
        bus_value = FLOAT_VALUE;
        for (int k = N - 1; k >= 0; k--)
            if (reg_bus_en[k]) bus_value = reg_bus_out[k*WIDTH +: WIDTH];
    end

    // Both indices are widened so the range check still works when
    // 2**IDXW > N.
    assign reject = (32'(src) >= 32'(N)) || (32'(dst) >= 32'(N)) || (src == dst);

`ifdef BUS_XFER_CONTENTION_EN
    // More than one driver (clearing the lowest set bit leaves some bit set),
    // or the source slot is not driving.
    assign cont_now = ((reg_bus_en & (reg_bus_en - N'(1))) != '0) ||
                      !reg_bus_en[src_q];
`else
    assign cont_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            cont     <= 1'b0;
            ready    <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            assert_n <= '1;
            load_n   <= '1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (req && ready) begin
                        src_q <= src;
                        dst_q <= dst;
                        cont  <= 1'b0;
                        ready <= 1'b0;
                        if (reject) begin
                            // A bad request skips the strobes entirely.
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state    <= DRIVE;
                            cnt      <= 4'(SETTLE - 1);
                            assert_n <= ~onehot(src);
                        end
                    end
                end
                DRIVE: begin
                    cont     <= cont | cont_now;
                    assert_n <= ~onehot(src_q);
                    if (cnt == 4'd0) begin
                        state  <= LOAD;
                        load_n <= ~onehot(dst_q);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                LOAD: begin
                    // The destination captures bus_value on the edge that
                    // leaves this state.
                    state    <= DONE;
                    assert_n <= '1;
                    load_n   <= '1;
                    done     <= 1'b1;
                    err      <= cont | cont_now;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
